cpu_run_controller: RTL and testbench
=====================================

CPU_RUN_CONTROLLER -- requirements
Module: cpu_run_controller

Interface
REQ-001 The module SHALL have parameter DIV_MID, default 100, meaning the clk_in cycles per cpu_en pulse for rate_sel=1.
REQ-002 The module SHALL have parameter DIV_SLOW, default 100_000_000, meaning the clk_in cycles per cpu_en pulse for rate_sel=2 and rate_sel=3.
REQ-003 The module SHALL have port clk_in, input, 1 bit: the system clock.
REQ-004 The module SHALL have port rst, input, 1 bit: the reset, asynchronous, active-high.
REQ-005 The module SHALL have ports btn_run, btn_step and btn_halt, each input, 1 bit: raw button levels, asynchronous to clk_in.
REQ-006 The module SHALL have port rate_sel, input, 2 bits: run rate (0=every cycle, 1=DIV_MID, 2 or 3=DIV_SLOW).
REQ-007 The module SHALL have port pc, input, 32 bits: the CPU's current program counter.
REQ-008 The module SHALL have ports bp_addr (input, 32 bits) and bp_valid (input, 1 bit): breakpoint address and enable.
REQ-009 The module SHALL have port cpu_en, output, 1 bit, registered: a one-cycle CPU advance strobe.
REQ-010 The module SHALL have port state, output, 2 bits: HALT=0, RUN=1, STEP=2.
REQ-011 The module SHALL have port step_count, output, 16 bits: count of cpu_en pulses, wrapping.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer followed by rising-edge detection; a raw rise sampled at edge E SHALL change state at edge E+2.
REQ-013 From HALT, a step edge SHALL load state=STEP and cpu_en=1 on the same edge; on the next edge it SHALL load state=HALT and cpu_en=0, giving exactly one pulse.
REQ-014 From HALT, a run edge SHALL enter RUN, clear the divider and set skip_bp=1.
REQ-015 In RUN, the divider SHALL increment each cycle; when it equals DIV-1, cpu_en SHALL be 1 for the next cycle and the divider SHALL wrap to 0; with rate_sel=0 (DIV=1), cpu_en SHALL be 1 every cycle from the cycle after RUN entry.
REQ-016 A change of rate_sel while in RUN SHALL clear the divider on the same edge, with no pulse issued on that edge.
REQ-017 A halt edge in RUN SHALL enter HALT and force cpu_en=0 on the same edge; a pending divider terminal count on that edge SHALL be dropped.
REQ-018 When edges coincide, halt SHALL beat run and run SHALL beat step; edges not valid in the current state (e.g. run in RUN, step in RUN or STEP) SHALL be ignored.
REQ-019 step_count SHALL increment by 1 on every edge that loads cpu_en=1, and SHALL wrap from 0xFFFF to 0.
REQ-020 cpu_en SHALL never be high in two consecutive cycles unless state=RUN and rate_sel=0.

Reset
REQ-021 While rst=1, the block SHALL hold state=HALT, cpu_en=0, step_count=0, divider=0, skip_bp=0 and all synchronizer and edge flops at 0.
REQ-022 An rst assertion mid-RUN or mid-STEP SHALL abort immediately, with no further cpu_en pulse.
REQ-023 A button held high through reset release SHALL NOT produce an edge.

Configuration
REQ-024 With BREAKPOINT_EN defined, a RUN pulse that would issue while bp_valid=1, pc==bp_addr and skip_bp=0 SHALL be suppressed, and state SHALL go to HALT on that edge.
REQ-025 With BREAKPOINT_EN defined, skip_bp SHALL clear on the first issued RUN pulse; STEP SHALL ignore breakpoints.
REQ-026 Without BREAKPOINT_EN, pc, bp_addr and bp_valid SHALL be unused, no comparator or skip_bp flop SHALL be built, and RUN SHALL leave only on halt or rst.

Structure
REQ-027 Package cpu_run_pkg SHALL hold the state enum (HALT/RUN/STEP), the rate_sel encodings and a function mapping rate_sel to a divisor.
REQ-028 Sub-module btn_sync_edge (2-flop synchronizer plus rising-edge pulse, async rst) SHALL be instantiated three times.
REQ-029 The divider SHALL be sized by $clog2(DIV_SLOW).

Verification (DIV_MID=4, DIV_SLOW=8)
REQ-030 Reset, then btn_step pulse -> exactly 1 cpu_en cycle, state 0->2->0, step_count=1.
REQ-031 btn_run with rate_sel=1 for 40 cycles -> cpu_en every 4th cycle (~10 pulses), state=1; then btn_halt -> cpu_en=0 within 3 edges, state=0.
REQ-032 rate_sel 1->2 mid-RUN -> next pulse 8 cycles after the change; simultaneous run+halt edges in HALT -> stays HALT.
REQ-033 BREAKPOINT_EN, bp_addr=0x10, pc=0x10, run -> first pulse issues (skip); next pulse is suppressed and state=HALT; re-run -> one pulse issues.
REQ-034 step_count preset via 0xFFFF steps (forced) -> next step gives 0; rst asserted mid-RUN at rate_sel=0 -> cpu_en=0 in the same cycle.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run controller: run states, rate_sel encodings and
// the rate_sel -> clk_in-cycles-per-pulse mapping.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } run_state_e;

  localparam logic [1:0] RATE_FULL     = 2'd0;
  localparam logic [1:0] RATE_MID      = 2'd1;
  localparam logic [1:0] RATE_SLOW     = 2'd2;
  localparam logic [1:0] RATE_SLOW_ALT = 2'd3;

  function automatic int unsigned rate_divisor(input logic [1:0]  sel,
                                               input int unsigned div_mid,
                                               input int unsigned div_slow);
    rate_divisor = div_slow;
    case (sel)
      RATE_FULL:               rate_divisor = 1;
      RATE_MID:                rate_divisor = div_mid;
      RATE_SLOW, RATE_SLOW_ALT: rate_divisor = div_slow;
    endcase
  endfunction

endpackage

// File: rtl/cpu_run_controller_btn_sync_edge.sv
// Button conditioner: 2-flop synchronizer plus one-cycle rising-edge pulse.
// A raw rise sampled at edge E makes o_rise high in the cycle ending at E+2.
module btn_sync_edge (
  input  logic clk_in,
  input  logic rst,
  input  logic i_btn,
  output logic o_rise
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic [1:0] r_live;
  logic       r_arm;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_live <= '0;
      r_arm  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_prev <= r_sync[1];
      r_live <= {r_live[0], 1'b1};
      // Arm only after a genuinely sampled low, so a button held through
      // reset release cannot look like a fresh press.
      r_arm  <= r_arm | (r_live[1] & ~r_sync[1]);
    end
  end

  assign o_rise = r_sync[1] & ~r_prev & r_arm;

endmodule

// File: rtl/cpu_run_controller.sv
// CPU run/step/halt controller producing a rate-divided cpu_en strobe.
// Optional feature: define BREAKPOINT_EN to halt RUN on a pc == bp_addr match.
module cpu_run_controller
  import cpu_run_pkg::*;
#(
  parameter int unsigned DIV_MID  = 100,
  parameter int unsigned DIV_SLOW = 100_000_000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        btn_halt,
  input  logic [1:0]  rate_sel,
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
  input  logic        bp_valid,
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic [15:0] step_count
);

  localparam int DW = (DIV_SLOW > 1) ? $clog2(DIV_SLOW) : 1;

  run_state_e      r_state, w_state_nxt;
  logic            r_cpu_en, w_en_nxt;
  logic [15:0]     r_step_cnt;
  logic [DW-1:0]   r_div, w_div_nxt, w_div_last;
  logic [1:0]      r_rate_q;
  logic            w_run_e, w_step_e, w_halt_e, w_rate_chg;

  btn_sync_edge u_run  (.clk_in(clk_in), .rst(rst), .i_btn(btn_run),  .o_rise(w_run_e));
  btn_sync_edge u_step (.clk_in(clk_in), .rst(rst), .i_btn(btn_step), .o_rise(w_step_e));
  btn_sync_edge u_halt (.clk_in(clk_in), .rst(rst), .i_btn(btn_halt), .o_rise(w_halt_e));

  assign w_div_last = DW'(rate_divisor(rate_sel, DIV_MID, DIV_SLOW) - 1);
  assign w_rate_chg = (rate_sel != r_rate_q);

`ifdef BREAKPOINT_EN
  logic r_skip_bp, w_skip_nxt, w_bp_hit;
  assign w_bp_hit = bp_valid && (pc == bp_addr) && !r_skip_bp;
`else
  logic w_unused_bp;
  assign w_unused_bp = ^{pc, bp_addr, bp_valid};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = 1'b0;
    w_div_nxt   = r_div;
`ifdef BREAKPOINT_EN
    w_skip_nxt  = r_skip_bp;
`endif
    case (r_state)
      ST_HALT: begin
        // halt beats run beats step
        if (!w_halt_e) begin
          if (w_run_e) begin
            w_state_nxt = ST_RUN;
            w_div_nxt   = '0;
`ifdef BREAKPOINT_EN
            w_skip_nxt  = 1'b1;
`endif
          end else if (w_step_e) begin
            w_state_nxt = ST_STEP;
            w_en_nxt    = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (w_halt_e) begin
          w_state_nxt = ST_HALT;
          w_div_nxt   = '0;
        end else if (w_rate_chg) begin
          w_div_nxt = '0;
        end else if (r_div == w_div_last) begin
          w_div_nxt = '0;
`ifdef BREAKPOINT_EN
          if (w_bp_hit) begin
            w_state_nxt = ST_HALT;
          end else begin
            w_en_nxt   = 1'b1;
            w_skip_nxt = 1'b0;
          end
`else
          w_en_nxt = 1'b1;
`endif
        end else begin
          w_div_nxt = r_div + DW'(1);
        end
      end
      ST_STEP: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_HALT;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state    <= ST_HALT;
      r_cpu_en   <= 1'b0;
      r_step_cnt <= '0;
      r_div      <= '0;
      r_rate_q   <= RATE_FULL;
    end else begin
      r_state  <= w_state_nxt;
      r_cpu_en <= w_en_nxt;
      r_div    <= w_div_nxt;
      r_rate_q <= rate_sel;
      if (w_en_nxt) r_step_cnt <= r_step_cnt + 16'd1;
    end
  end

`ifdef BREAKPOINT_EN
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_skip_bp <= 1'b0;
    else     r_skip_bp <= w_skip_nxt;
  end
`endif

  assign cpu_en     = r_cpu_en;
  assign state      = r_state;
  assign step_count = r_step_cnt;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Randomized + directed bench for cpu_run_controller against an event-level model.
module tb_cpu_run_controller;

  localparam int unsigned DM = 4;
  localparam int unsigned DS = 8;

  logic        clk_in = 1'b0, rst = 1'b0;
  logic        btn_run = 1'b0, btn_step = 1'b0, btn_halt = 1'b0, bp_valid = 1'b0;
  logic [1:0]  rate_sel = 2'd0;
  logic [31:0] pc = 32'h0, bp_addr = 32'h0;
  logic        cpu_en;
  logic [1:0]  state;
  logic [15:0] step_count;

  int vec_cnt = 0, err_cnt = 0;

  always #5 clk_in = ~clk_in;

  cpu_run_controller #(.DIV_MID(DM), .DIV_SLOW(DS)) dut (
    .clk_in(clk_in), .rst(rst), .btn_run(btn_run), .btn_step(btn_step),
    .btn_halt(btn_halt), .rate_sel(rate_sel), .pc(pc), .bp_addr(bp_addr),
    .bp_valid(bp_valid), .cpu_en(cpu_en), .state(state), .step_count(step_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a button counts as pressed two edges after its raw
  // 0->1 sample; RUN issues a pulse whenever the number of edges since the
  // last (re)start is a positive multiple of the divisor.
  int          m_state;
  bit          m_en, m_skip;
  logic [15:0] m_cnt;
  int          ph;
  logic [1:0]  m_prev_rate;
  bit   [3:0]  h_run, h_step, h_halt;

  always @(posedge clk_in or posedge rst) begin
    if (rst) begin
      m_state = 0; m_en = 0; m_cnt = 0; ph = 0; m_skip = 0; m_prev_rate = 0;
      h_run = '1; h_step = '1; h_halt = '1;
    end else begin : mdl
      bit er, es, eh, pulse;
      int dv;
      h_run  = {h_run[2:0],  btn_run};
      h_step = {h_step[2:0], btn_step};
      h_halt = {h_halt[2:0], btn_halt};
      er = h_run[2]  & ~h_run[3];
      es = h_step[2] & ~h_step[3];
      eh = h_halt[2] & ~h_halt[3];
      dv = (rate_sel == 0) ? 1 : (rate_sel == 1) ? int'(DM) : int'(DS);
      pulse = 0;
      case (m_state)
        0: if (!eh) begin
             if (er) begin m_state = 1; ph = 0; m_skip = 1; end
             else if (es) begin m_state = 2; pulse = 1; end
           end
        2: m_state = 0;
        default: begin
          if (eh) m_state = 0;
          else if (rate_sel != m_prev_rate) ph = 0;
          else begin
            ph++;
            if (ph % dv == 0) begin
`ifdef BREAKPOINT_EN
              if (bp_valid && pc == bp_addr && !m_skip) m_state = 0;
              else begin pulse = 1; m_skip = 0; end
`else
              pulse = 1;
`endif
            end
          end
        end
      endcase
      m_prev_rate = rate_sel;
      m_en = pulse;
      if (pulse) m_cnt++;
    end
  end

  always @(negedge clk_in) begin
    chk("cpu_en", {31'd0, cpu_en}, {31'd0, m_en});
    chk("state", {30'd0, state}, 32'(m_state));
    chk("step_count", {16'd0, step_count}, {16'd0, m_cnt});
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
    #1;
  endtask

  task automatic press(input int b);
    if (b == 0) btn_run = 1; else if (b == 1) btn_step = 1; else btn_halt = 1;
    cyc(2);
    btn_run = 0; btn_step = 0; btn_halt = 0;
  endtask

  task automatic do_reset();
    rst = 1; cyc(2); rst = 0; cyc(3);
  endtask

  task automatic wait_state(input logic [1:0] tgt, input int budget, input string nm);
    int n;
    n = 0;
    while (state !== tgt && n < budget) begin cyc(1); n++; end
    chk(nm, {30'd0, state}, {30'd0, tgt});
  endtask

  initial begin : stim
    int pulses, saw, n;
    #1 rst = 1;
    cyc(2);
    chk("rst_state", {30'd0, state}, 0);
    chk("rst_en", {31'd0, cpu_en}, 0);
    chk("rst_cnt", {16'd0, step_count}, 0);
    rst = 0; cyc(3);

    // single step
    rate_sel = 1;
    btn_step = 1; pulses = 0; saw = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (i == 1) btn_step = 0;
      if (cpu_en) pulses++;
      if (state == 2) saw = 1;
    end
    chk("step_pulses", pulses, 1);
    chk("step_saw_step", saw, 1);
    chk("step_back_halt", {30'd0, state}, 0);
    chk("step_count1", {16'd0, step_count}, 1);

    // run at DIV_MID
    press(0);
    wait_state(2'd1, 10, "run_enter");
    pulses = 0;
    for (int i = 0; i < 40; i++) begin cyc(1); if (cpu_en) pulses++; end
    chk("run_mid_pulses", pulses, 10);
    btn_halt = 1; cyc(2); btn_halt = 0; cyc(1);
    chk("halt_en", {31'd0, cpu_en}, 0);
    chk("halt_state", {30'd0, state}, 0);
    cyc(3);

    // rate change mid-RUN
    press(0);
    wait_state(2'd1, 10, "run_enter2");
    cyc(5);
    rate_sel = 2; n = 0;
    do begin cyc(1); n++; end while (!cpu_en && n < 20);
    chk("rate_chg_gap", n - 1, 8);
    press(2); cyc(4);

    // coincident run+halt in HALT
    btn_run = 1; btn_halt = 1; cyc(2); btn_run = 0; btn_halt = 0;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin cyc(1); if (cpu_en) pulses++; end
    chk("run_halt_state", {30'd0, state}, 0);
    chk("run_halt_pulses", pulses, 0);

    // button held through reset release
    btn_run = 1; rst = 1; cyc(2); rst = 0; cyc(8);
    chk("held_through_reset", {30'd0, state}, 0);
    btn_run = 0; cyc(3);

    // breakpoint
    rate_sel = 1; bp_addr = 32'h10; pc = 32'h10; bp_valid = 1;
`ifdef BREAKPOINT_EN
    for (int k = 0; k < 2; k++) begin
      press(0);
      wait_state(2'd1, 10, "bp_run_enter");
      pulses = 0; n = 0;
      while (state != 0 && n < 40) begin cyc(1); n++; if (cpu_en) pulses++; end
      chk("bp_pulses", pulses, 1);
      chk("bp_halted", {30'd0, state}, 0);
      cyc(3);
    end
`else
    press(0);
    wait_state(2'd1, 10, "nobp_run_enter");
    cyc(30);
    chk("nobp_still_run", {30'd0, state}, 1);
    press(2); cyc(4);
`endif
    bp_valid = 0;

    // randomized traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      btn_run  = ($urandom_range(0, 9) == 0);
      btn_step = ($urandom_range(0, 7) == 0);
      btn_halt = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) rate_sel = 2'($urandom_range(0, 3));
      pc       = ($urandom_range(0, 1) == 0) ? 32'h10 : 32'h14;
      bp_valid = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    btn_run = 0; btn_step = 0; btn_halt = 0; bp_valid = 0;
    cyc(3);

    // step_count wrap via full-rate run then steps
    do_reset();
    rate_sel = 0;
    press(0);
    n = 0;
    while (step_count < 16'hFFF0 && n < 70000) begin cyc(1); n++; end
    chk("reach_fff0", {31'd0, step_count >= 16'hFFF0}, 1);
    press(2); cyc(5);
    chk("wrap_halt", {30'd0, state}, 0);
    n = 0;
    while (step_count != 16'hFFFF && n < 40) begin press(1); cyc(4); n++; end
    chk("pre_wrap", {16'd0, step_count}, 32'hFFFF);
    press(1); cyc(4);
    chk("wrap_zero", {16'd0, step_count}, 0);

    // reset aborts full-rate RUN immediately
    press(0);
    wait_state(2'd1, 10, "full_run_enter");
    cyc(4);
    chk("full_rate_en", {31'd0, cpu_en}, 1);
    #2 rst = 1;
    #1 chk("rst_abort_en", {31'd0, cpu_en}, 0);
    chk("rst_abort_state", {30'd0, state}, 0);
    cyc(2); rst = 0; cyc(3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
